msx_bus_initiator: RTL and testbench

- Host-side counterpart of the cartridge bus front end: runs Z80-timed MSX memory and I/O cycles on request from internal logic.
- Presents the resulting address and control lines through the 3-group, 8-bit multiplexer protocol (one-hot-low MUX_CS_n selects which group appears on MUX_SIG).
- Used as the host model in system simulation and on boards where the FPGA drives a cartridge slot.

---
 rtl/msx_bus_initiator.sv | 199 +++++++++++++++++++
 tb/tb_msx_bus_initiator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_initiator.sv
// rtl/msx_bus_initiator.sv - Z80-timed MSX bus cycle initiator with 3-group mux responder (optional MSX_BUS_WAIT_TIMEOUT_EN)
module msx_bus_initiator #(
    parameter int         MSEL_A0_A7  = 1,
    parameter int         MSEL_A8_A15 = 0,
    parameter logic [3:0] SLOT_PAGES  = 4'b0110,
    parameter int         RESET_TICKS = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN,
    input  logic        REQ,
    input  logic        REQ_IO,
    input  logic        REQ_WR,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        ACK,
    output logic        DONE,
    output logic [7:0]  RDATA,
    output logic        ERR,
    output logic [15:0] ADDR,
    output logic [7:0]  DOUT,
    output logic        DOE,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic        SLTSL_n,
    output logic        CS1_n,
    output logic        CS2_n,
    output logic        CS12_n,
    output logic        M1_n,
    output logic        RFSH_n,
    output logic        BUS_RESET_n,
    input  logic        WAIT_n,
    input  logic [7:0]  DIN,
    input  logic [2:0]  MUX_CS_n,
    output logic [7:0]  MUX_SIG
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_TW   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;

    localparam logic [15:0] RST_LAST = 16'(RESET_TICKS - 1);

    logic [2:0]  state;
    logic        cyc_io;
    logic        cyc_wr;
    logic [15:0] rst_cnt;
`ifdef MSX_BUS_WAIT_TIMEOUT_EN
    logic [7:0]  wait_cnt;
`endif

    assign M1_n   = 1'b1;
    assign RFSH_n = 1'b1;

    // Return every strobe/select to idle and signal cycle completion.
    task automatic release_bus();
        MERQ_n  <= 1'b1;
        IORQ_n  <= 1'b1;
        RD_n    <= 1'b1;
        WR_n    <= 1'b1;
        SLTSL_n <= 1'b1;
        CS1_n   <= 1'b1;
        CS2_n   <= 1'b1;
        CS12_n  <= 1'b1;
        DOE     <= 1'b0;
        DONE    <= 1'b1;
        state   <= ST_IDLE;
    endtask

    // Bus reset stretcher and T-state sequencer; everything advances only on CLK_EN.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cyc_io      <= 1'b0;
            cyc_wr      <= 1'b0;
            rst_cnt     <= '0;
            BUS_RESET_n <= 1'b0;
            ACK         <= 1'b0;
            DONE        <= 1'b0;
            RDATA       <= 8'h00;
            ADDR        <= 16'h0000;
            DOUT        <= 8'h00;
            DOE         <= 1'b0;
            MERQ_n      <= 1'b1;
            IORQ_n      <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            SLTSL_n     <= 1'b1;
            CS1_n       <= 1'b1;
            CS2_n       <= 1'b1;
            CS12_n      <= 1'b1;
`ifdef MSX_BUS_WAIT_TIMEOUT_EN
            ERR         <= 1'b0;
            wait_cnt    <= 8'd0;
`endif
        end else begin
            ACK  <= 1'b0;
            DONE <= 1'b0;
`ifdef MSX_BUS_WAIT_TIMEOUT_EN
            ERR  <= 1'b0;
`endif
            if (CLK_EN && !BUS_RESET_n) begin
                if (rst_cnt == RST_LAST) begin
                    BUS_RESET_n <= 1'b1;
                end else begin
                    rst_cnt <= rst_cnt + 16'd1;
                end
            end
            if (CLK_EN) begin
                case (state)
                    ST_IDLE: begin
                        if (REQ && BUS_RESET_n) begin
                            cyc_io <= REQ_IO;
                            cyc_wr <= REQ_WR;
                            ADDR   <= REQ_ADDR;
                            ACK    <= 1'b1;
                            state  <= ST_T1;
                            if (REQ_WR) begin
                                DOUT <= REQ_WDATA;
                                DOE  <= 1'b1;
                            end
                        end
                    end
                    ST_T1: begin
                        // Memory strobes and selects go active here; I/O waits for TW.
                        if (!cyc_io) begin
                            MERQ_n  <= 1'b0;
                            RD_n    <= cyc_wr;
                            WR_n    <= !cyc_wr;
                            SLTSL_n <= !SLOT_PAGES[ADDR[15:14]];
                            CS1_n   <= !(ADDR[15:14] == 2'd1);
                            CS2_n   <= !(ADDR[15:14] == 2'd2);
                            CS12_n  <= !(ADDR[15:14] == 2'd1 || ADDR[15:14] == 2'd2);
                        end
                        state <= ST_T2;
                    end
                    ST_T2, ST_TW: begin
                        if (state == ST_T2 && cyc_io) begin
                            // Automatic I/O wait state.
                            IORQ_n <= 1'b0;
                            RD_n   <= cyc_wr;
                            WR_n   <= !cyc_wr;
                            state  <= ST_TW;
                        end else if (WAIT_n) begin
                            state <= ST_T3;
`ifdef MSX_BUS_WAIT_TIMEOUT_EN
                            wait_cnt <= 8'd0;
`endif
                        end else begin
`ifdef MSX_BUS_WAIT_TIMEOUT_EN
                            if (wait_cnt == 8'd254) begin
                                wait_cnt <= 8'd0;
                                RDATA    <= 8'hFF;
                                ERR      <= 1'b1;
                                release_bus();
                            end else begin
                                wait_cnt <= wait_cnt + 8'd1;
                            end
`endif
                        end
                    end
                    ST_T3: begin
                        if (!cyc_wr) begin
                            RDATA <= DIN;
                        end
                        release_bus();
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifndef MSX_BUS_WAIT_TIMEOUT_EN
    assign ERR = 1'b0;
`endif

    // Mux responder: pick the group selected by the one-hot-low MUX_CS_n.
    always_comb begin
        MUX_SIG = 8'hFF;
        case (MUX_CS_n)
            3'b110: begin
                if (MSEL_A0_A7 == 0)       MUX_SIG = ADDR[7:0];
                else if (MSEL_A8_A15 == 0) MUX_SIG = ADDR[15:8];
            end
            3'b101: begin
                if (MSEL_A0_A7 == 1)       MUX_SIG = ADDR[7:0];
                else if (MSEL_A8_A15 == 1) MUX_SIG = ADDR[15:8];
            end
            3'b011: MUX_SIG = {M1_n, CS12_n, RFSH_n, BUS_RESET_n, CS2_n, CS1_n, IORQ_n, MERQ_n};
            default: MUX_SIG = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// tb/tb_msx_bus_initiator.sv - directed self-checking bench for msx_bus_initiator
module tb_msx_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CLK_EN = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_IO = 1'b0;
    logic        REQ_WR = 1'b0;
    logic [15:0] REQ_ADDR = 16'h0000;
    logic [7:0]  REQ_WDATA = 8'h00;
    logic        ACK, DONE, ERR, DOE;
    logic [7:0]  RDATA, DOUT, MUX_SIG;
    logic [15:0] ADDR;
    logic        MERQ_n, IORQ_n, RD_n, WR_n, SLTSL_n, CS1_n, CS2_n, CS12_n;
    logic        M1_n, RFSH_n, BUS_RESET_n;
    logic        WAIT_n = 1'b1;
    logic [7:0]  DIN = 8'h00;
    logic [2:0]  MUX_CS_n = 3'b111;

    int checks = 0;
    int errors = 0;
    logic ack_s, done_s, err_s;
    int n;

    msx_bus_initiator dut (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN), .REQ(REQ), .REQ_IO(REQ_IO),
        .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .ACK(ACK),
        .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .ADDR(ADDR), .DOUT(DOUT), .DOE(DOE),
        .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .SLTSL_n(SLTSL_n),
        .CS1_n(CS1_n), .CS2_n(CS2_n), .CS12_n(CS12_n), .M1_n(M1_n), .RFSH_n(RFSH_n),
        .BUS_RESET_n(BUS_RESET_n), .WAIT_n(WAIT_n), .DIN(DIN), .MUX_CS_n(MUX_CS_n),
        .MUX_SIG(MUX_SIG)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus T-state: a single-CLK CLK_EN pulse, pulse outputs captured right after the edge.
    task automatic tick();
        @(negedge CLK) CLK_EN = 1'b1;
        @(negedge CLK) CLK_EN = 1'b0;
        ack_s  = ACK;
        done_s = DONE;
        err_s  = ERR;
        repeat (2) @(negedge CLK);
    endtask

    // Bounded wait for DONE; n is the tick index at which it appeared, 0 if never.
    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done_s) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK) RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic release_reset_window();
        for (int i = 1; i <= 16; i++) tick();
    endtask

    initial begin
        // Reset values
        do_reset();
        chk16("rst_addr", ADDR, 16'h0000);
        chk8("rst_rdata", RDATA, 8'h00);
        chk8("rst_dout", DOUT, 8'h00);
        chk1("rst_doe", DOE, 1'b0);
        chk1("rst_merq", MERQ_n, 1'b1);
        chk1("rst_sltsl", SLTSL_n, 1'b1);
        chk1("rst_busrst", BUS_RESET_n, 1'b0);
        chk1("rst_ack", ACK, 1'b0);
        chk1("rst_err", ERR, 1'b0);
        chk1("rst_m1", M1_n, 1'b1);

        // Reset window: REQ ignored, BUS_RESET_n rises on the 16th CLK_EN
        REQ = 1'b1; REQ_ADDR = 16'h4000;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk1("win_busrst_low", BUS_RESET_n, 1'b0);
            chk1("win_no_ack", ack_s, 1'b0);
        end
        tick();
        chk1("win_busrst_16", BUS_RESET_n, 1'b1);
        chk1("win_no_ack_16", ack_s, 1'b0);
        REQ = 1'b0;
        tick();
        chk1("idle_no_ack", ack_s, 1'b0);

        // Memory read at 4000
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h4000; DIN = 8'h5A; WAIT_n = 1'b1;
        tick();
        chk1("mr_ack", ack_s, 1'b1);
        chk16("mr_addr", ADDR, 16'h4000);
        chk1("mr_t1_merq", MERQ_n, 1'b1);
        REQ = 1'b0;
        tick();
        chk1("mr_merq", MERQ_n, 1'b0);
        chk1("mr_rd", RD_n, 1'b0);
        chk1("mr_wr", WR_n, 1'b1);
        chk1("mr_sltsl", SLTSL_n, 1'b0);
        chk1("mr_cs1", CS1_n, 1'b0);
        chk1("mr_cs2", CS2_n, 1'b1);
        chk1("mr_cs12", CS12_n, 1'b0);
        chk1("mr_iorq", IORQ_n, 1'b1);
        chk1("mr_doe", DOE, 1'b0);
        tick();
        chk1("mr_t3_merq", MERQ_n, 1'b0);
        chk1("mr_t3_done", done_s, 1'b0);
        tick();
        chk1("mr_done", done_s, 1'b1);
        chk1("mr_err", err_s, 1'b0);
        chk8("mr_rdata", RDATA, 8'h5A);
        chk1("mr_end_merq", MERQ_n, 1'b1);
        chk1("mr_end_rd", RD_n, 1'b1);
        chk1("mr_end_sltsl", SLTSL_n, 1'b1);
        chk16("mr_addr_hold", ADDR, 16'h4000);

        // I/O write to 00A8
        REQ = 1'b1; REQ_IO = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 16'h00A8; REQ_WDATA = 8'h3C; DIN = 8'h77;
        tick();
        chk1("iow_ack", ack_s, 1'b1);
        chk8("iow_dout", DOUT, 8'h3C);
        chk1("iow_doe", DOE, 1'b1);
        REQ = 1'b0;
        tick();
        chk1("iow_t2_iorq", IORQ_n, 1'b1);
        chk1("iow_t2_wr", WR_n, 1'b1);
        tick();
        chk1("iow_tw_iorq", IORQ_n, 1'b0);
        chk1("iow_tw_wr", WR_n, 1'b0);
        chk1("iow_tw_rd", RD_n, 1'b1);
        chk1("iow_merq", MERQ_n, 1'b1);
        chk1("iow_sltsl", SLTSL_n, 1'b1);
        tick();
        chk1("iow_t3_iorq", IORQ_n, 1'b0);
        chk1("iow_t3_done", done_s, 1'b0);
        tick();
        chk1("iow_done", done_s, 1'b1);
        chk1("iow_end_iorq", IORQ_n, 1'b1);
        chk1("iow_end_doe", DOE, 1'b0);
        chk8("iow_rdata_kept", RDATA, 8'h5A);

        // Memory read at 8000 with 3 WAIT ticks
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h8000; DIN = 8'hA5;
        tick();
        chk1("wt_ack", ack_s, 1'b1);
        REQ = 1'b0;
        tick();
        chk1("wt_cs2", CS2_n, 1'b0);
        chk1("wt_cs1", CS1_n, 1'b1);
        chk1("wt_sltsl", SLTSL_n, 1'b0);
        WAIT_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("wt_hold_done", done_s, 1'b0);
            chk1("wt_hold_merq", MERQ_n, 1'b0);
        end
        WAIT_n = 1'b1;
        wait_done(10, n);
        chk16("wt_len", 16'(n + 5), 16'd7);
        chk8("wt_rdata", RDATA, 8'hA5);

        // Mux groups during T2 of a memory write to 12F0
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b1; REQ_ADDR = 16'h12F0; REQ_WDATA = 8'h99;
        tick();
        REQ = 1'b0;
        tick();
        chk1("mx_wr", WR_n, 1'b0);
        chk1("mx_sltsl", SLTSL_n, 1'b1);
        MUX_CS_n = 3'b110; #1;
        chk8("mx_g0", MUX_SIG, 8'h12);
        MUX_CS_n = 3'b101; #1;
        chk8("mx_g1", MUX_SIG, 8'hF0);
        MUX_CS_n = 3'b011; #1;
        chk8("mx_g2", MUX_SIG, 8'hFE);
        MUX_CS_n = 3'b111; #1;
        chk8("mx_none", MUX_SIG, 8'hFF);
        MUX_CS_n = 3'b000; #1;
        chk8("mx_multi", MUX_SIG, 8'hFF);
        MUX_CS_n = 3'b111;
        wait_done(5, n);
        chk16("mx_len", 16'(n + 2), 16'd4);
        MUX_CS_n = 3'b011; #1;
        chk8("mx_g2_idle", MUX_SIG, 8'hFF);
        MUX_CS_n = 3'b111;

        // Back-to-back with REQ held high at C000
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'hC000; DIN = 8'h11;
        tick();
        chk1("bb_ack1", ack_s, 1'b1);
        tick();
        chk1("bb_sltsl", SLTSL_n, 1'b1);
        chk1("bb_cs12", CS12_n, 1'b1);
        chk1("bb_merq", MERQ_n, 1'b0);
        wait_done(5, n);
        chk16("bb_len", 16'(n + 2), 16'd4);
        chk8("bb_rdata", RDATA, 8'h11);
        tick();
        chk1("bb_ack2", ack_s, 1'b1);
        REQ = 1'b0;
        tick();
        chk1("bb2_merq", MERQ_n, 1'b0);

        // Reset mid-cycle
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) RESET = 1'b0;
        chk1("mid_merq", MERQ_n, 1'b1);
        chk1("mid_rd", RD_n, 1'b1);
        chk1("mid_busrst", BUS_RESET_n, 1'b0);
        chk16("mid_addr", ADDR, 16'h0000);
        chk8("mid_rdata", RDATA, 8'h00);
        release_reset_window();
        chk1("mid_busrst_up", BUS_RESET_n, 1'b1);

`ifdef MSX_BUS_WAIT_TIMEOUT_EN
        // WAIT stuck low: abort after 255 wait ticks
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h4000; DIN = 8'h22;
        tick();
        chk1("to_ack", ack_s, 1'b1);
        REQ = 1'b0;
        tick();
        WAIT_n = 1'b0;
        wait_done(300, n);
        chk16("to_len", 16'(n), 16'd255);
        chk1("to_err", err_s, 1'b1);
        chk8("to_rdata", RDATA, 8'hFF);
        chk1("to_merq", MERQ_n, 1'b1);
        chk1("to_rd", RD_n, 1'b1);
        chk1("to_sltsl", SLTSL_n, 1'b1);
        WAIT_n = 1'b1;
        tick();
        chk1("to_err_clear", ERR, 1'b0);
`else
        // Without the timeout, WAIT stretches the cycle indefinitely and ERR stays 0
        REQ = 1'b1; REQ_IO = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h4000; DIN = 8'h22;
        tick();
        chk1("nt_ack", ack_s, 1'b1);
        REQ = 1'b0;
        tick();
        WAIT_n = 1'b0;
        wait_done(300, n);
        chk16("nt_no_done", 16'(n), 16'd0);
        chk1("nt_merq", MERQ_n, 1'b0);
        chk1("nt_err", ERR, 1'b0);
        WAIT_n = 1'b1;
        wait_done(5, n);
        chk16("nt_release", 16'(n), 16'd2);
        chk8("nt_rdata", RDATA, 8'h22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
